booth_seq_ctrl: RTL and testbench
=================================

// Module: booth_seq_ctrl
// PURPOSE
//  Sequencer/initiator for the radix-4 Booth step unit (booth). Accepts a signed
//  multiplicand/multiplier pair over valid/ready, recodes the multiplier into
//  overlapping 3-bit triplets (MSB group first), drives one step per group into
//  the step unit, and Horner-accumulates (acc<<2 + step) into a signed product.
//  The step unit adds +/-M or +/-2M unweighted; all weighting is done here.
// PARAMETERS
//  WIDTH   8   operand width; must be even; product is 2*WIDTH; NSTEP = WIDTH/2
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        reset, asynchronous, active-low
//  in_valid     in   1        operand pair valid
//  in_ready     out  1        high only in IDLE
//  in_mcand     in   WIDTH    signed multiplicand M (two's complement)
//  in_mplier    in   WIDTH    signed multiplier B (two's complement)
//  out_valid    out  1        product valid; held until out_ready
//  out_ready    in   1        consumer accepts product
//  out_prod     out  2*WIDTH  signed product M*B; stable while out_valid
//  busy         out  1        high in ISSUE/WAIT/DONE
//  step_mult_1  out  3        Booth triplet {B[2i+1],B[2i],B[2i-1]}, B[-1]=0
//  step_mult_2  out  WIDTH    latched M
//  step_pre     out  2*WIDTH  acc<<2 (upper bits dropped, wraps mod 2^(2*WIDTH))
//  step_en      out  1        step request, registered, one cycle per step
//  step_rdy     in   1        step result valid
//  step_next    in   2*WIDTH  step result = step_pre + d_i*M
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1 (combinational from IDLE); out_valid=0;
//   out_prod=0; busy=0; step_en=0; step_mult_1=0; step_mult_2=0; step_pre=0;
//   acc=0; idx=0. Reset mid-operation discards all state; no product emitted.
//  FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  IDLE: on in_valid&in_ready latch M,B; acc<=0; idx<=NSTEP-1; -> ISSUE.
//  ISSUE: step_en<=1, step_mult_1<=triplet(idx), step_mult_2<=M,
//   step_pre<=acc<<2 (all registered together); -> WAIT.
//  WAIT: step_en<=0. If step_rdy: acc<=step_next; if idx==0 -> DONE
//   (out_prod<=step_next, out_valid<=1) else idx<=idx-1, -> ISSUE.
//   If step_rdy low: hold in WAIT indefinitely, acc/idx unchanged.
//  step_rdy is sampled only in WAIT; ignored in all other states.
//  DONE: out_valid=1, out_prod stable; on out_ready -> IDLE, out_valid<=0.
//   in_valid ignored while not IDLE (no overlap, no queueing).
//  Latency with zero-stall step unit: accept edge E -> out_valid high after
//   edge E+2*NSTEP (E+8 for WIDTH=8); throughput 1 op / (2*NSTEP+2) cycles.
//  Triplets 000/111 still issue a step (fixed timing, no skipping).
//  Arithmetic: final acc = sum d_i*M*4^i = M*B exactly; intermediate
//   step_pre truncation is harmless mod 2^(2*WIDTH). -2^(W-1) operands legal.
// TESTING
//  M=7,B=5 -> triplets 000,000,010,010 issued in order; out_prod=35 at E+8.
//  M=-128,B=-128 -> out_prod=16384 (0x4000); M=-128,B=127 -> -16256 (0xC080).
//  M=0x5A,B=0 -> 4 steps issued, all triplets 000; out_prod=0; M=-1,B=-1 -> 1.
//  out_ready held low 5 cycles after out_valid -> out_prod/out_valid stable,
//   in_ready=0, new in_valid not accepted; accepted the cycle after handshake.
//  step_rdy held low 3 cycles in step 2 -> FSM stays WAIT, result unchanged,
//   out_valid delayed exactly 3 cycles; M=-3,B=6 -> -18.
//  rst_n pulsed low during WAIT of step 1 -> all outputs to reset values
//   asynchronously; next op M=3,B=-4 -> -12 with no stale acc contribution.

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// Operand/product handshake and Booth step-unit bus
// for the radix-4 Booth sequencer.
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_mcand;
    logic [WIDTH-1:0]   in_mplier;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;

    modport master (
        output in_valid, in_mcand, in_mplier, out_ready,
        input  in_ready, out_valid, out_prod
    );

    modport slave (
        input  in_valid, in_mcand, in_mplier, out_ready,
        output in_ready, out_valid, out_prod
    );
endinterface

interface booth_step_if #(
    parameter int WIDTH = 8
);
    logic [2:0]         step_mult_1;
    logic [WIDTH-1:0]   step_mult_2;
    logic [2*WIDTH-1:0] step_pre;
    logic               step_en;
    logic               step_rdy;
    logic [2*WIDTH-1:0] step_next;

    modport master (
        output step_mult_1, step_mult_2, step_pre, step_en,
        input  step_rdy, step_next
    );

    modport slave (
        input  step_mult_1, step_mult_2, step_pre, step_en,
        output step_rdy, step_next
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Radix-4 Booth sequencer: recodes B into triplets MSB-first,
// issues one step per group and Horner-accumulates the result.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    booth_seq_ctrl_if.slave   op,
    booth_step_if.master      stp,
    output logic              busy
);
    localparam int NSTEP = WIDTH / 2;
    localparam int PW    = 2 * WIDTH;
    localparam int IW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_prod_q, out_prod_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic [2:0]       trip_q, trip_d;
    logic [WIDTH-1:0] m2_q, m2_d;
    logic [PW-1:0]    pre_q, pre_d;

    logic [WIDTH:0]   ext;
    logic [2:0]       trip;

    assign op.in_ready    = (state_q == IDLE);
    assign op.out_valid   = out_valid_q;
    assign op.out_prod    = out_prod_q;
    assign stp.step_en     = en_q;
    assign stp.step_mult_1 = trip_q;
    assign stp.step_mult_2 = m2_q;
    assign stp.step_pre    = pre_q;
    assign busy            = busy_q;

    // Select triplet {B[2i+1],B[2i],B[2i-1]} for the current group
    always_comb begin
        ext  = {mplier_q, 1'b0};
        trip = 3'b000;
        for (int i = 0; i < NSTEP; i++) begin
            if (idx_q == IW'(i)) trip = ext[2*i +: 3];
        end
    end

    // Next-state and registered-output logic of the sequencer
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_prod_d  = out_prod_q;
        en_d        = en_q;
        trip_d      = trip_q;
        m2_d        = m2_q;
        pre_d       = pre_q;
        unique case (state_q)
            IDLE: begin
                if (op.in_valid) begin
                    mcand_d  = op.in_mcand;
                    mplier_d = op.in_mplier;
                    acc_d    = '0;
                    idx_d    = IW'(NSTEP - 1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                en_d    = 1'b1;
                trip_d  = trip;
                m2_d    = mcand_q;
                pre_d   = {acc_q[PW-3:0], 2'b00};
                state_d = WAIT;
            end
            WAIT: begin
                en_d = 1'b0;
                if (stp.step_rdy) begin
                    acc_d = stp.step_next;
                    if (idx_q == '0) begin
                        out_prod_d  = stp.step_next;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                if (op.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Single state register for FSM, datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            busy_q      <= 1'b0;
            en_q        <= 1'b0;
            trip_q      <= '0;
            m2_q        <= '0;
            pre_q       <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_prod_q  <= out_prod_d;
            busy_q      <= busy_d;
            en_q        <= en_d;
            trip_q      <= trip_d;
            m2_q        <= m2_d;
            pre_q       <= pre_d;
        end
    end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl with a behavioural
// Booth step unit that can stall a chosen step.
module tb_booth_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    booth_seq_ctrl_if #(.WIDTH(8)) op_if ();
    booth_step_if     #(.WIDTH(8)) st_if ();

    booth_seq_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .op    (op_if),
        .stp   (st_if),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] trip;
        logic [7:0] m;
    } step_exp_t;

    typedef struct {
        logic [15:0] prod;
        int          lat;
    } prod_exp_t;

    step_exp_t step_q[$];
    prod_exp_t prod_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [15:0] cur_exp = '0;
    logic ov_prev;

    int stall_step = -1;
    int stall_len = 0;
    logic pend;
    int wcnt;
    int step_no;
    logic active;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] stepf(input logic [2:0] t,
                                          input logic [7:0] m,
                                          input logic [15:0] pre);
        logic [15:0] ms;
        ms = {{8{m[7]}}, m};
        case (t)
            3'b001, 3'b010: return pre + ms;
            3'b011:         return pre + (ms << 1);
            3'b100:         return pre - (ms << 1);
            3'b101, 3'b110: return pre - ms;
            default:        return pre;
        endcase
    endfunction

    // Behavioural step unit: zero-stall unless this step is stalled
    assign active = st_if.step_en | pend;
    assign st_if.step_rdy = active &&
        (wcnt >= ((step_no == stall_step) ? stall_len : 0));
    assign st_if.step_next = stepf(st_if.step_mult_1,
                                   st_if.step_mult_2,
                                   st_if.step_pre);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            wcnt <= 0;
            step_no <= 0;
        end else begin
            if (op_if.in_valid && op_if.in_ready) step_no <= 0;
            else if (st_if.step_rdy) step_no <= step_no + 1;
            if (st_if.step_rdy) begin
                pend <= 1'b0;
                wcnt <= 0;
            end else if (active) begin
                pend <= 1'b1;
                wcnt <= wcnt + 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Step monitor: every issued step must match the next triplet
    always @(negedge clk) begin
        if (rst_n && st_if.step_en) begin
            if (step_q.size() == 0) begin
                chk("step_unexpected", 32'd1, 32'd0);
            end else begin
                step_exp_t e;
                e = step_q.pop_front();
                chk("triplet", 32'(st_if.step_mult_1), 32'(e.trip));
                chk("mult_2", 32'(st_if.step_mult_2), 32'(e.m));
            end
        end
    end

    // Output monitor: product, latency and hold stability
    always @(negedge clk) begin
        if (rst_n && op_if.in_valid && op_if.in_ready)
            acc_cyc = cyc + 1;
        if (rst_n && op_if.out_valid && !ov_prev) begin
            if (prod_q.size() == 0) begin
                chk("prod_unexpected", 32'd1, 32'd0);
            end else begin
                prod_exp_t e;
                e = prod_q.pop_front();
                cur_exp = e.prod;
                chk("prod", 32'(op_if.out_prod), 32'(e.prod));
                chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end else if (rst_n && op_if.out_valid && ov_prev) begin
            chk("prod_hold", 32'(op_if.out_prod), 32'(cur_exp));
            chk("in_ready_hold", 32'(op_if.in_ready), 32'd0);
        end
        ov_prev <= rst_n & op_if.out_valid;
    end

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(op_if.in_ready), 32'd1);
        chk("rst_out_valid", 32'(op_if.out_valid), 32'd0);
        chk("rst_out_prod", 32'(op_if.out_prod), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step_en", 32'(st_if.step_en), 32'd0);
        chk("rst_mult_1", 32'(st_if.step_mult_1), 32'd0);
        chk("rst_mult_2", 32'(st_if.step_mult_2), 32'd0);
        chk("rst_pre", 32'(st_if.step_pre), 32'd0);
    endtask

    task automatic accept(input logic [7:0] m, input logic [7:0] b);
        int n;
        op_if.in_valid = 1'b1;
        op_if.in_mcand = m;
        op_if.in_mplier = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_if.in_ready && n < 40);
        if (!op_if.in_ready) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        op_if.in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] b,
                          input logic [11:0] trips,
                          input logic [15:0] prod,
                          input int sstep, input int slen,
                          input int hold);
        int n;
        stall_step = sstep;
        stall_len = slen;
        for (int i = 3; i >= 0; i--)
            step_q.push_back('{trips[3*i +: 3], m});
        prod_q.push_back('{prod, 8 + slen});
        accept(m, b);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_if.out_valid && n < 60);
        if (!op_if.out_valid) chk("out_timeout", 32'd1, 32'd0);
        if (hold > 0) begin
            op_if.in_valid = 1'b1;
            op_if.in_mcand = 8'h63;
            op_if.in_mplier = 8'h63;
            repeat (hold) @(negedge clk);
            op_if.in_valid = 1'b0;
        end
        op_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        op_if.out_ready = 1'b0;
        chk("out_valid_clr", 32'(op_if.out_valid), 32'd0);
        chk("in_ready_after", 32'(op_if.in_ready), 32'd1);
    endtask

    initial begin
        op_if.in_valid = 1'b0;
        op_if.in_mcand = '0;
        op_if.in_mplier = '0;
        op_if.out_ready = 1'b0;
        #2;
        check_reset_vals();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'd7, 8'd5, 12'b000_000_010_010, 16'd35, -1, 0, 0);
        run_op(8'h80, 8'h80, 12'b100_000_000_000, 16'h4000, -1, 0, 0);
        run_op(8'h80, 8'd127, 12'b011_111_111_110, 16'hC080, -1, 0, 0);
        run_op(8'h5A, 8'd0, 12'b000_000_000_000, 16'h0000, -1, 0, 0);
        run_op(8'hFF, 8'hFF, 12'b111_111_111_110, 16'h0001, -1, 0, 0);
        run_op(8'd2, 8'd3, 12'b000_000_001_110, 16'd6, -1, 0, 5);
        run_op(8'hFD, 8'd6, 12'b000_000_011_100, 16'hFFEE, 1, 3, 0);

        // Abort an op while its first step is stalled in WAIT
        stall_step = 0;
        stall_len = 1000;
        step_q.push_back('{3'b000, 8'd5});
        accept(8'd5, 8'd9);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        stall_len = 0;
        @(posedge clk);
        #1;
        run_op(8'd3, 8'hFC, 12'b111_111_110_000, 16'hFFF4, -1, 0, 0);

        repeat (3) @(negedge clk);
        chk("step_q_empty", 32'(step_q.size()), 32'd0);
        chk("prod_q_empty", 32'(prod_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
